// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keycode receiver.
// Holds the frame FSM state encoding, scan-code prefixes and the parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_NO_KEY = 8'h00;

  // PS/2 frames carry odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronisers, falling-edge detect, frame FSM and
// mid-frame timeout. Emits one strobe per good byte or one error pulse per bad frame.
module ps2_frame_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       frame_err
);
  import ps2_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic                   clk_prev_r;
  logic                   fall_s;
  logic                   data_s;
  logic                   tout_hit_s;

  ps2_state_t    state_r;
  logic [7:0]    shift_r;
  logic [2:0]    bit_cnt_r;
  logic          parity_r;
  logic [TW-1:0] tout_r;
  logic [7:0]    rx_byte_r;
  logic          byte_stb_r;
  logic          frame_err_r;

  // Synchroniser chains; lines idle high so they reset to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_r  <= {SYNC_STAGES{1'b1}};
      data_sync_r <= {SYNC_STAGES{1'b1}};
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
      clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
    end
  end

  // Edge detect and timeout qualifier; a falling edge always beats the timeout.
  always_comb begin
    fall_s     = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
    data_s     = data_sync_r[SYNC_STAGES-1];
    tout_hit_s = (tout_r == TOUT_MAX) & ~fall_s;
  end

  // Frame FSM with timeout counter and registered strobe/error outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      shift_r     <= 8'h00;
      bit_cnt_r   <= 3'd0;
      parity_r    <= 1'b0;
      tout_r      <= '0;
      rx_byte_r   <= 8'h00;
      byte_stb_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      byte_stb_r  <= 1'b0;
      frame_err_r <= 1'b0;

      if (fall_s || (state_r == IDLE)) begin
        tout_r <= '0;
      end else if (tout_r != TOUT_MAX) begin
        tout_r <= tout_r + TW'(1);
      end else begin
        tout_r <= tout_r;
      end

      case (state_r)
        IDLE: begin
          if (fall_s && !data_s) begin
            state_r   <= DATA;
            bit_cnt_r <= 3'd0;
          end else begin
            state_r <= IDLE;
          end
        end
        DATA: begin
          if (fall_s) begin
            shift_r   <= {data_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= PARITY;
            end else begin
              state_r <= DATA;
            end
          end else if (tout_hit_s) begin
            state_r     <= IDLE;
            frame_err_r <= 1'b1;
          end else begin
            state_r <= DATA;
          end
        end
        PARITY: begin
          if (fall_s) begin
            parity_r <= data_s;
            state_r  <= STOP;
          end else if (tout_hit_s) begin
            state_r     <= IDLE;
            frame_err_r <= 1'b1;
          end else begin
            state_r <= PARITY;
          end
        end
        STOP: begin
          if (fall_s) begin
            state_r <= IDLE;
            if (odd_parity_ok(shift_r, parity_r) && data_s) begin
              rx_byte_r  <= shift_r;
              byte_stb_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else if (tout_hit_s) begin
            state_r     <= IDLE;
            frame_err_r <= 1'b1;
          end else begin
            state_r <= STOP;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign rx_byte   = rx_byte_r;
  assign byte_stb  = byte_stb_r;
  assign frame_err = frame_err_r;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard front end: turns received scan-code bytes into the currently
// held make code, honouring F0 (break) and E0 (extended) prefixes.
module ps2_keycode_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       frame_err
);
  import ps2_pkg::*;

  logic [7:0] rx_byte_s;
  logic       byte_stb_s;
  logic       frame_err_s;

  logic       brk_r;
  logic       ext_r;
  logic [7:0] key_code_r;
  logic       key_valid_r;

  ps2_frame_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte_s),
    .byte_stb  (byte_stb_s),
    .frame_err (frame_err_s)
  );

  // Byte interpretation; extended keys are swallowed, releases only clear a matching key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brk_r       <= 1'b0;
      ext_r       <= 1'b0;
      key_code_r  <= PS2_NO_KEY;
      key_valid_r <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      if (byte_stb_s) begin
        if (rx_byte_s == PS2_BREAK) begin
          brk_r <= 1'b1;
        end else if (rx_byte_s == PS2_EXT) begin
          ext_r <= 1'b1;
        end else if (ext_r) begin
          brk_r <= 1'b0;
          ext_r <= 1'b0;
        end else if (brk_r) begin
          brk_r <= 1'b0;
          if (rx_byte_s == key_code_r) begin
            key_code_r <= PS2_NO_KEY;
          end else begin
            key_code_r <= key_code_r;
          end
        end else begin
          key_code_r  <= rx_byte_s;
          key_valid_r <= 1'b1;
        end
      end else begin
        key_code_r <= key_code_r;
      end
    end
  end

  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign frame_err = frame_err_s;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx with a scaled-down PS/2 bit period
// and timeout so the run stays short; expectations come from a byte-level key model.
module tb_ps2_keycode_rx;

  localparam int TOUT = 200;
  localparam int HL   = 20;  // ps2_clk low phase, in clk cycles
  localparam int HQ   = 10;  // half of the high phase; data changes here

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_valid;
  logic       frame_err;

  int n_tests;
  int n_fail;
  int valid_cnt;
  int err_cnt;
  int overlap_cnt;

  logic [7:0] m_key;
  logic       m_brk;
  logic       m_ext;
  int         m_valid;
  int         m_err;

  ps2_keycode_rx #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_code  (key_code),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (key_valid) valid_cnt++;
      if (frame_err) err_cnt++;
      if (key_valid && frame_err) overlap_cnt++;
    end
  end

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (m_ext) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (m_brk) begin
      m_brk = 1'b0;
      if (b == m_key) m_key = 8'h00;
    end else begin
      m_key = b;
      m_valid++;
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HQ) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HL) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HQ) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (8) @(negedge clk);
    if (bad_par || bad_stop) m_err++;
    else model_byte(b);
  endtask

  task automatic check_state(input string name);
    n_tests++;
    if (key_code !== m_key) begin
      n_fail++;
      $display("FAIL %s key_code: got %h expected %h", name, key_code, m_key);
    end
    n_tests++;
    if (valid_cnt !== m_valid) begin
      n_fail++;
      $display("FAIL %s key_valid pulses: got %0d expected %0d", name, valid_cnt, m_valid);
    end
    n_tests++;
    if (err_cnt !== m_err) begin
      n_fail++;
      $display("FAIL %s frame_err pulses: got %0d expected %0d", name, err_cnt, m_err);
    end
  endtask

  task automatic check_key(input string name, input logic [7:0] exp);
    n_tests++;
    if (key_code !== exp) begin
      n_fail++;
      $display("FAIL %s: key_code got %h expected %h", name, key_code, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    m_key = 8'h00;
    m_brk = 1'b0;
    m_ext = 1'b0;
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({key_code, key_valid, frame_err} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got %h/%b/%b expected 00/0/0", key_code, key_valid, frame_err);
    end
    do_reset();
    check_state("after_reset");
  endtask

  // Make code with cycle-exact latency check around the stop-bit edge.
  task automatic test_make();
    logic [7:0] b;
    b = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HQ) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (key_valid !== 1'b0 || key_code !== 8'h00) begin
      n_fail++;
      $display("FAIL make_early: valid %b code %h expected 0 and 00", key_valid, key_code);
    end
    @(negedge clk);
    n_tests++;
    if (key_valid !== 1'b1 || key_code !== 8'h1C) begin
      n_fail++;
      $display("FAIL make_latency: valid %b code %h expected 1 and 1c", key_valid, key_code);
    end
    @(negedge clk);
    n_tests++;
    if (key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL make_pulse_width: valid %b expected 0", key_valid);
    end
    repeat (HL - 3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HQ + 8) @(negedge clk);
    model_byte(b);
    check_state("make_1c");
  endtask

  task automatic test_break();
    send_frame(8'hF0, 1'b0, 1'b0);
    check_key("break_prefix_hold", 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_key("break_release", 8'h00);
    check_state("break_1c");
  endtask

  task automatic test_last_wins();
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h23, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_key("old_release_ignored", 8'h23);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h23, 1'b0, 1'b0);
    check_key("new_release", 8'h00);
    check_state("last_wins");
  endtask

  task automatic test_frame_errors();
    send_frame(8'h2A, 1'b0, 1'b0);
    send_frame(8'h1B, 1'b1, 1'b0);
    check_key("bad_parity_keeps_key", 8'h2A);
    check_state("bad_parity");
    send_frame(8'h1B, 1'b0, 1'b1);
    check_key("bad_stop_keeps_key", 8'h2A);
    check_state("bad_stop");
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (140) @(negedge clk);
    n_tests++;
    if (err_cnt !== e0) begin
      n_fail++;
      $display("FAIL timeout_early: frame_err pulses %0d expected %0d", err_cnt, e0);
    end
    repeat (100) @(negedge clk);
    m_err++;
    check_state("timeout");
    send_frame(8'h2B, 1'b0, 1'b0);
    check_key("after_timeout", 8'h2B);
    check_state("after_timeout");
  endtask

  task automatic test_extended();
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_key("extended_ignored", 8'h2B);
    check_state("extended");
  endtask

  task automatic test_reset_mid_frame();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    do_reset();
    check_key("mid_frame_reset", 8'h00);
    send_frame(8'h24, 1'b0, 1'b0);
    check_key("after_mid_reset", 8'h24);
    check_state("after_mid_reset");
  endtask

  task automatic test_random();
    logic [7:0] b;
    int k;
    for (int n = 0; n < 24; n++) begin
      k = $urandom_range(0, 9);
      b = 8'($urandom_range(0, 255));
      case (k)
        0: send_frame(8'hF0, 1'b0, 1'b0);
        1: send_frame(8'hE0, 1'b0, 1'b0);
        2: send_frame(m_key, 1'b0, 1'b0);
        3: send_frame(b, 1'b1, 1'b0);
        4: send_frame(b, 1'b0, 1'b1);
        default: send_frame(b, 1'b0, 1'b0);
      endcase
      check_state("random");
    end
  endtask

  task automatic test_no_overlap();
    n_tests++;
    if (overlap_cnt !== 0) begin
      n_fail++;
      $display("FAIL valid_err_overlap: %0d cycles expected 0", overlap_cnt);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    valid_cnt = 0; err_cnt = 0; overlap_cnt = 0;
    m_key = 8'h00; m_brk = 1'b0; m_ext = 1'b0; m_valid = 0; m_err = 0;
    test_reset();
    test_make();
    test_break();
    test_last_wins();
    test_frame_errors();
    test_timeout();
    test_extended();
    test_reset_mid_frame();
    test_random();
    test_no_overlap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
